line_buffer_3row: RTL and testbench
===================================

# line_buffer_3row

Upstream stage of the 3x3 edge-detection window operator. Accepts a raster-order pixel stream of one pixel per valid cycle and buffers the two previous image lines in internal line memories. Emits three vertically aligned pixels (row r-2, r-1, r) for each incoming pixel of row r ≥ 2. The three outputs drive the window operator's `din1`/`din2`/`din3` inputs directly.

## Interface
- `WIDTH`, 8, pixel width in bits.
- `PIC_WIDTH`, 480, pixels per line; legal range 3..511.
- `PIC_HEIGHT`, 272, lines per frame; legal range 3..511.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `valid_in`  in  1  `din` carries a pixel this cycle.
- `sof`  in  1  start of frame; qualified by `valid_in`; marks the current pixel as (row 0, col 0).
- `din`  in  WIDTH  input pixel.
- `dout1`  out  WIDTH  pixel at the same column, row r-2 (top row of the window).
- `dout2`  out  WIDTH  pixel at the same column, row r-1.
- `dout3`  out  WIDTH  pixel at the same column, row r (current input, delayed).
- `valid_out`  out  1  `dout1..3` valid this cycle.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Line memories:
  - `lineA[PIC_WIDTH]` holds row r-1.
  - `lineB[PIC_WIDTH]` holds row r-2.
  - Memory contents are not reset. Stale data is never exposed, because `valid_out` is gated by the row count.
- Counters:
  - `col`, 0..PIC_WIDTH-1.
  - `row`, 0..PIC_HEIGHT-1.
  - Both are 9 bits and reset to 0.
- On each `valid_in` cycle at address `col`:
  - Read `a = lineA[col]` and `b = lineB[col]`.
  - Write `lineB[col] <= a` and `lineA[col] <= din`.
  - Register `dout1 <= b`, `dout2 <= a`, `dout3 <= din`.
  - Register `valid_out <= (row >= 2)`.
- Read-before-write applies at the same address: the values read are the pre-write contents.
- Counter advance on `valid_in`:
  - If `col == PIC_WIDTH-1`: set `col <= 0` and advance `row`.
  - Otherwise: `col <= col+1`.
- Row wrap:
  - If `row == PIC_HEIGHT-1` and `col == PIC_WIDTH-1`: set `row <= 0` and `frame_done <= 1` for one cycle.
- `sof` resync (`valid_in && sof`):
  - The pixel is processed as (0,0), regardless of the current counter values.
  - `valid_out` for it is 0.
  - Afterwards `col <= 1` and `row <= 0`.
  - Stale line memory data is overwritten naturally over the next two lines.
  - No `frame_done` is generated by a resync.
- `sof` without `valid_in` is ignored.
- `valid_in` low:
  - Counters, memories and `dout1..3` hold.
  - `valid_out <= 0`.
  - `frame_done <= 0`.
- Back-to-back frames with no gap are supported. Row 0 of the next frame overwrites `lineA` while `lineB` shifts.

## Timing
- Latency is 1 cycle: the pixel accepted at edge N appears on `dout3` with `valid_out` = 1 after edge N.
- Throughput is 1 pixel per cycle. There is no backpressure; the downstream block must accept every `valid_out` cycle.
- Reset values: `dout1 = dout2 = dout3 = 0`, `valid_out = 0`, `frame_done = 0`, `col = 0`, `row = 0`.
- `frame_done` asserts in the same cycle as `valid_out` for the last pixel, (PIC_HEIGHT-1, PIC_WIDTH-1).
- Asynchronous reset mid-frame:
  - Outputs and counters clear immediately.
  - The first `valid_in` pixel after deassertion is treated as (0,0).
  - No `valid_out` is produced for the next 2·PIC_WIDTH accepted pixels.
- Memory implementation: either inferred registers or a simple dual-port RAM is acceptable. If a synchronous-read RAM is used, the 1-cycle latency and the read-before-write semantics above must still hold.
- `valid_out` pattern: one frame yields exactly (PIC_HEIGHT-2)·PIC_WIDTH `valid_out` pulses.

## Test plan
Benches use PIC_WIDTH=4, PIC_HEIGHT=4, WIDTH=8, and pixel value = `row*16 + col` unless stated otherwise.

- **Reset:** assert `rst_n` = 0 with `valid_in` toggling → all outputs 0 throughout; `frame_done` never pulses.
- **Fill and align:** stream 16 pixels continuously with `sof` on the first.
  - No `valid_out` for the first 8 pixels.
  - The cycle after pixel 0x20: `dout1` = 0x00, `dout2` = 0x10, `dout3` = 0x20, `valid_out` = 1.
  - The cycle after 0x33: `dout1` = 0x13, `dout2` = 0x23, `dout3` = 0x33, `frame_done` = 1.
  - Exactly 8 `valid_out` pulses in total.
- **Gapped input:** same stream with `valid_in` low on every other cycle → identical output sequence; `valid_out` is 0 and `dout1..3` hold during gaps.
- **Back-to-back frames:** second frame uses pixel value + 0x80 and follows with no gap.
  - No `valid_out` for rows 0-1 of frame 2.
  - At pixel 0xA1: `dout1` = 0x81, `dout2` = 0x91, `dout3` = 0xA1.
- **Mid-line resync:** after 6 pixels of a frame, apply `sof` with `din` = 0x00 and restart the stream → the counter restarts; the first `valid_out` comes with `dout3` = 0x20; no `frame_done` at the resync.
- **Reset mid-frame:** pull `rst_n` low after pixel 0x21 → outputs clear the same cycle; after release, a fresh stream behaves exactly like the "Fill and align" case.

Source files
------------

// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, three vertically aligned pixels out, for the 3x3 window operator.
// No backpressure: the slave (line buffer) consumes every valid_in, the master sinks every valid_out.
interface line_buffer_3row_if #(
  parameter int WIDTH = 8
);
  logic             valid_in;
  logic             sof;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic             valid_out;
  logic             frame_done;

  modport master (
    output valid_in, sof, din,
    input  dout1, dout2, dout3, valid_out, frame_done
  );

  modport slave (
    input  valid_in, sof, din,
    output dout1, dout2, dout3, valid_out, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-line buffer giving rows r-2/r-1/r per pixel of row r>=2; 1-cycle latency.
// No backpressure: one pixel per cycle accepted unconditionally, downstream must take every valid_out.
module line_buffer_3row #(
  parameter int WIDTH      = 8,
  parameter int PIC_WIDTH  = 480,
  parameter int PIC_HEIGHT = 272
) (
  input  logic                clk,
  input  logic                rst_n,
  line_buffer_3row_if.slave   bus
);
  localparam int         AW       = $clog2(PIC_WIDTH);
  localparam logic [8:0] LAST_COL = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] LAST_ROW = 9'(PIC_HEIGHT - 1);

  logic [8:0]       col, row;
  logic [8:0]       cur_col, cur_row;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             last_col, last_px;

  logic [WIDTH-1:0] line_a [PIC_WIDTH];
  logic [WIDTH-1:0] line_b [PIC_WIDTH];

  // sof forces the current pixel to (0,0) whatever the counters say
  always_comb begin
    cur_col  = bus.sof ? 9'd0 : col;
    cur_row  = bus.sof ? 9'd0 : row;
    addr     = cur_col[AW-1:0];
    rd_a     = line_a[addr];
    rd_b     = line_b[addr];
    last_col = (cur_col == LAST_COL);
    last_px  = last_col && (cur_row == LAST_ROW);
  end

  // Combinational read plus edge write gives read-before-write at the same address
  always_ff @(posedge clk) begin
    if (bus.valid_in) begin
      line_b[addr] <= rd_a;
      line_a[addr] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      bus.dout1      <= '0;
      bus.dout2      <= '0;
      bus.dout3      <= '0;
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else if (bus.valid_in) begin
      bus.dout1      <= rd_b;
      bus.dout2      <= rd_a;
      bus.dout3      <= bus.din;
      bus.valid_out  <= (cur_row >= 9'd2);
      bus.frame_done <= last_px;
      if (last_col) begin
        col <= '0;
        row <= last_px ? 9'd0 : cur_row + 9'd1;
      end else begin
        col <= cur_col + 9'd1;
        row <= cur_row;
      end
    end else begin
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: directed raster frames plus random traffic, checked against a
// pixel-history model (output rows are simply the pixels W and 2W positions earlier in the stream).
module tb_line_buffer_3row;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int FR = W * H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  line_buffer_3row_if #(.WIDTH(8)) bus ();

  line_buffer_3row #(.WIDTH(8), .PIC_WIDTH(W), .PIC_HEIGHT(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int vcount;

  // Reference: pixels accepted since the last sync, position n counted from the sync
  logic [7:0] hist[$];
  int         n;
  logic [7:0] e1, e2, e3;
  logic       ev, efd, known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    hist.delete();
    n     = 0;
    e1    = '0;
    e2    = '0;
    e3    = '0;
    ev    = 1'b0;
    efd   = 1'b0;
    known = 1'b1;
  endtask

  task automatic compare_outputs();
    check("valid_out", 32'(bus.valid_out), 32'(ev));
    check("frame_done", 32'(bus.frame_done), 32'(efd));
    check("dout3", 32'(bus.dout3), 32'(e3));
    if (known) begin
      check("dout1", 32'(bus.dout1), 32'(e1));
      check("dout2", 32'(bus.dout2), 32'(e2));
    end
    if (bus.valid_out === 1'b1) vcount++;
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    int p;
    bus.valid_in = v;
    bus.sof      = s;
    bus.din      = d;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (v) begin
      if (s) begin
        hist.delete();
        n = 0;
      end
      p   = n % FR;
      ev  = (p / W) >= 2;
      efd = (p == FR - 1);
      if (ev) begin
        e1    = hist[0];
        e2    = hist[W];
        known = 1'b1;
      end else begin
        known = 1'b0;
      end
      e3 = d;
      hist.push_back(d);
      if (hist.size() > 2 * W) void'(hist.pop_front());
      n++;
    end else begin
      ev  = 1'b0;
      efd = 1'b0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  // Pixel i of a raster run carries base + row*16 + col
  task automatic send_pixels(input logic [7:0] base, input bit sof_first, input bit gapped, input int count);
    for (int i = 0; i < count; i++) begin
      step(1'b1, sof_first && (i == 0), base + 8'((i / W) * 16 + (i % W)));
      if (gapped) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  task automatic async_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    check("rst_now_valid", 32'(bus.valid_out), 32'd0);
    check("rst_now_fdone", 32'(bus.frame_done), 32'd0);
    check("rst_now_dout1", 32'(bus.dout1), 32'd0);
    check("rst_now_dout2", 32'(bus.dout2), 32'd0);
    check("rst_now_dout3", 32'(bus.dout3), 32'd0);
    model_clear();
    for (int i = 0; i < cycles; i++)
      step(1'(i % 2), 1'($urandom_range(0, 1)), 8'($urandom));
    rst_n = 1'b1;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.sof      = 1'b0;
    bus.din      = '0;
    model_clear();
    async_reset(6);

    vcount = 0;
    send_pixels(8'h00, 1'b1, 1'b0, FR);
    check("fill_pulses", 32'(vcount), 32'((H - 2) * W));
    step(1'b0, 1'b0, 8'h00);

    vcount = 0;
    send_pixels(8'h00, 1'b1, 1'b1, FR);
    check("gap_pulses", 32'(vcount), 32'((H - 2) * W));

    vcount = 0;
    send_pixels(8'h00, 1'b1, 1'b0, FR);
    send_pixels(8'h80, 1'b0, 1'b0, FR);
    check("b2b_pulses", 32'(vcount), 32'(2 * (H - 2) * W));

    send_pixels(8'h00, 1'b1, 1'b0, 6);
    vcount = 0;
    send_pixels(8'h00, 1'b1, 1'b0, FR);
    check("resync_pulses", 32'(vcount), 32'((H - 2) * W));

    send_pixels(8'h00, 1'b1, 1'b0, 10);
    async_reset(3);
    vcount = 0;
    send_pixels(8'h00, 1'b0, 1'b0, FR);
    check("postrst_pulses", 32'(vcount), 32'((H - 2) * W));

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 40) == 0), 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
